// File: rtl/csdf_rr_acc.sv
`default_nettype none
// ============================================================================
// Module      : csdf_rr_acc
// Description : Round-robin arbiter over FLUX cyclo-static dataflow flows.
//               Each firing reads one token from every port of the granted
//               flow. The firing combines those tokens into a value, and
//               that value is accumulated for NUM_OP firings before one
//               tagged result is written downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module csdf_rr_acc #(
  parameter int PORTS  = 2,
  parameter int FLUX   = 2,
  parameter int WIDTH  = 8,
  parameter int NUM_OP = 4,
  parameter int MODE   = 0
) (
  input  logic                          ck,
  input  logic                          rst,
  input  logic [WIDTH*PORTS*FLUX-1:0]   in_data,
  input  logic [PORTS*FLUX-1:0]         in_empty,
  output logic [PORTS*FLUX-1:0]         in_read,
  input  logic                          out0_full,
  output logic                          out0_wr,
  output logic [WIDTH-1:0]              out0_data
);

  localparam int c_tw = (FLUX > 1) ? $clog2(FLUX) : 1;
  localparam int c_dw = WIDTH - c_tw;
  localparam int c_cw = (NUM_OP > 1) ? $clog2(NUM_OP) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(NUM_OP - 1);
  localparam logic [c_tw-1:0] c_ptr_rst = c_tw'(FLUX - 1);

  // Combining operator shared by the port fold and the accumulation.
  function automatic logic [c_dw-1:0] f_op(input logic [c_dw-1:0] a,
                                           input logic [c_dw-1:0] b);
    logic [c_dw:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (MODE == 2)      return (a > b) ? a : b;
    else if (MODE == 1) return s[c_dw] ? {c_dw{1'b1}} : s[c_dw-1:0];
    else                return s[c_dw-1:0];
  endfunction

  logic [c_cw-1:0] r_cnt [FLUX];
  logic [c_dw-1:0] r_acc [FLUX];
  logic [c_tw-1:0] r_rr_ptr;

  logic [FLUX-1:0] w_elig;
  logic            w_gnt_vld;
  logic [c_tw-1:0] w_gnt;
  logic [c_dw-1:0] w_v;
  logic [c_dw-1:0] w_n;
  logic            w_gnt_last;

  genvar f;
  generate
    for (f = 0; f < FLUX; f++) begin : g_flow
      logic w_ready;
      // A flow at its completing firing needs room downstream; others do not.
      assign w_ready   = ~|in_empty[f*PORTS +: PORTS];
      assign w_elig[f] = w_ready & ((r_cnt[f] != c_last) | ~out0_full);
      // Read strobes go to every port of the granted flow only.
      assign in_read[f*PORTS +: PORTS] =
        {PORTS{w_gnt_vld & (w_gnt == c_tw'(f)) & ~rst}};
    end
  endgenerate

  // Round-robin search starting after the last granted flow; the descending
  // loop leaves the earliest eligible flow in search order as the winner.
  always_comb begin
    int              idx;
    logic [c_tw-1:0] sel;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    idx       = 0;
    sel       = '0;
    for (int i = FLUX; i >= 1; i--) begin
      idx = (int'(r_rr_ptr) + i) % FLUX;
      sel = c_tw'(idx);
      if (w_elig[sel]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = sel;
      end
    end
  end

  // Fold the data fields of the granted flow's ports, then apply to its accumulator.
  always_comb begin
    logic [WIDTH-1:0] tok;
    tok = '0;
    w_v = '0;
    for (int p = 0; p < PORTS; p++) begin
      tok = in_data[(int'(w_gnt) * PORTS + p) * WIDTH +: WIDTH];
      w_v = f_op(w_v, tok[c_dw-1:0]);
    end
    w_n        = f_op(r_acc[w_gnt], w_v);
    w_gnt_last = (r_cnt[w_gnt] == c_last);
  end

  // Per-flow accumulation state, arbitration pointer and output register.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FLUX; i++) begin
        r_cnt[i] <= '0;
        r_acc[i] <= '0;
      end
      r_rr_ptr  <= c_ptr_rst;
      out0_wr   <= 1'b0;
      out0_data <= '0;
    end else begin
      out0_wr <= 1'b0;
      if (w_gnt_vld) begin
        r_rr_ptr <= w_gnt;
        if (w_gnt_last) begin
          out0_wr        <= 1'b1;
          out0_data      <= {w_gnt, w_n};
          r_acc[w_gnt]   <= '0;
          r_cnt[w_gnt]   <= '0;
        end else begin
          r_acc[w_gnt]   <= w_n;
          r_cnt[w_gnt]   <= r_cnt[w_gnt] + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csdf_rr_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_csdf_rr_acc
// Description : Directed scoreboard bench for csdf_rr_acc. One instance uses
//               wrapping sums and a second uses saturating sums. Both share
//               data and full inputs; each has its own empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csdf_rr_acc;

  typedef struct packed {
    int         cyc;
    logic [7:0] d;
  } exp_t;

  logic       ck = 1'b0;
  logic       rst;
  logic [31:0] in_data;
  logic [3:0] in_empty;
  logic [3:0] in_empty1;
  logic       out0_full;
  logic [3:0] in_read0, in_read1;
  logic       out0_wr0, out0_wr1;
  logic [7:0] out0_data0, out0_data1;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  csdf_rr_acc #(.PORTS(2), .FLUX(2), .WIDTH(8), .NUM_OP(4), .MODE(0)) dut0 (
    .ck(ck), .rst(rst), .in_data(in_data), .in_empty(in_empty),
    .in_read(in_read0), .out0_full(out0_full), .out0_wr(out0_wr0),
    .out0_data(out0_data0)
  );

  csdf_rr_acc #(.PORTS(2), .FLUX(2), .WIDTH(8), .NUM_OP(4), .MODE(1)) dut1 (
    .ck(ck), .rst(rst), .in_data(in_data), .in_empty(in_empty1),
    .in_read(in_read1), .out0_full(out0_full), .out0_wr(out0_wr1),
    .out0_data(out0_data1)
  );

  always #5 ck = ~ck;

  always @(posedge ck) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_flow(input int f, input logic [7:0] a, input logic [7:0] b);
    in_data[(f*2)*8 +: 8]   = a;
    in_data[(f*2+1)*8 +: 8] = b;
  endtask

  // One cycle of stimulus; read strobes are checked before the next rising edge.
  task automatic fire(input logic [3:0] e0_in, input logic [3:0] e1_in, input logic full,
                      input logic [3:0] rd0, input logic [3:0] rd1);
    @(negedge ck);
    in_empty  = e0_in;
    in_empty1 = e1_in;
    out0_full = full;
    #1;
    chk("dut0 in_read", {28'd0, in_read0}, {28'd0, rd0});
    chk("dut1 in_read", {28'd0, in_read1}, {28'd0, rd1});
  endtask

  task automatic push0(input logic [7:0] d);
    q0.push_back('{cyc: cyc + 1, d: d});
  endtask

  task automatic push1(input logic [7:0] d);
    q1.push_back('{cyc: cyc + 1, d: d});
  endtask

  task automatic do_reset();
    @(negedge ck);
    in_empty  = 4'hF;
    in_empty1 = 4'hF;
    rst       = 1'b1;
    @(negedge ck);
    rst       = 1'b0;
  endtask

  // Scoreboard monitors: every write must match the head of its queue in data and cycle.
  always @(negedge ck) begin
    if (!rst && out0_wr0) begin
      if (q0.size() == 0) chk("dut0 unexpected write", {24'd0, out0_data0}, 32'hFFFF_FFFF);
      else begin
        e0 = q0.pop_front();
        chk("dut0 out0_data", {24'd0, out0_data0}, {24'd0, e0.d});
        chk("dut0 write cycle", cyc, e0.cyc);
      end
    end
  end

  always @(negedge ck) begin
    if (!rst && out0_wr1) begin
      if (q1.size() == 0) chk("dut1 unexpected write", {24'd0, out0_data1}, 32'hFFFF_FFFF);
      else begin
        e1 = q1.pop_front();
        chk("dut1 out0_data", {24'd0, out0_data1}, {24'd0, e1.d});
        chk("dut1 write cycle", cyc, e1.cyc);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_empty  = 4'h0;
    in_empty1 = 4'hF;
    out0_full = 1'b0;
    set_flow(0, 8'd1, 8'd2);
    set_flow(1, 8'h83, 8'h84);

    // Reset state, including across a clock edge with all of flow 0/1 ready.
    #3;
    chk("reset in_read", {28'd0, in_read0}, 32'd0);
    chk("reset out0_wr", {31'd0, out0_wr0}, 32'd0);
    chk("reset out0_data", {24'd0, out0_data0}, 32'd0);
    @(posedge ck); #1;
    chk("reset in_read after edge", {28'd0, in_read0}, 32'd0);
    chk("reset out0_wr after edge", {31'd0, out0_wr0}, 32'd0);
    @(negedge ck);
    in_empty = 4'hF;
    rst      = 1'b0;

    // Flow 0 alone, {1,2} x4 -> {0,12}.
    for (int i = 0; i < 4; i++) begin
      fire(4'b1100, 4'hF, 1'b0, 4'b0011, 4'b0000);
      if (i == 3) push0(8'h0C);
    end
    for (int i = 0; i < 3; i++) fire(4'hF, 4'hF, 1'b0, 4'b0000, 4'b0000);

    // Both flows ready: alternate 0,1,...; flow 1 tokens carry tag bits that must be ignored.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      fire(4'b0000, 4'hF, 1'b0, (i % 2 == 1) ? 4'b1100 : 4'b0011, 4'b0000);
      if (i == 6) push0(8'h0C);
      if (i == 7) push0(8'h9C);
    end
    for (int i = 0; i < 2; i++) fire(4'hF, 4'hF, 1'b0, 4'b0000, 4'b0000);

    // Flow 1 parked at its last firing while downstream is full; flow 0 keeps going.
    do_reset();
    set_flow(1, 8'd5, 8'd5);
    for (int i = 0; i < 3; i++) fire(4'b0011, 4'hF, 1'b0, 4'b1100, 4'b0000);
    set_flow(0, 8'd1, 8'd1);
    for (int i = 0; i < 3; i++) fire(4'b0000, 4'hF, 1'b1, 4'b0011, 4'b0000);
    fire(4'b0000, 4'hF, 1'b1, 4'b0000, 4'b0000);
    fire(4'b0000, 4'hF, 1'b0, 4'b1100, 4'b0000);
    push0(8'hA8);
    fire(4'b0000, 4'hF, 1'b0, 4'b0011, 4'b0000);
    push0(8'h08);
    for (int i = 0; i < 2; i++) fire(4'hF, 4'hF, 1'b0, 4'b0000, 4'b0000);

    // {100,100} x4: wrapping gives 32, saturating gives 127.
    do_reset();
    set_flow(0, 8'd100, 8'd100);
    for (int i = 0; i < 4; i++) begin
      fire(4'b1100, 4'b1100, 1'b0, 4'b0011, 4'b0011);
      if (i == 3) begin
        push0(8'h20);
        push1(8'h7F);
      end
    end
    for (int i = 0; i < 2; i++) fire(4'hF, 4'hF, 1'b0, 4'b0000, 4'b0000);

    // Asynchronous reset between edges with flow 0 part-way through.
    set_flow(0, 8'd1, 8'd2);
    for (int i = 0; i < 2; i++) fire(4'b1100, 4'hF, 1'b0, 4'b0011, 4'b0000);
    @(posedge ck); #2;
    rst = 1'b1;
    #1;
    chk("async rst out0_data dut0", {24'd0, out0_data0}, 32'd0);
    chk("async rst out0_data dut1", {24'd0, out0_data1}, 32'd0);
    chk("async rst out0_wr", {31'd0, out0_wr0}, 32'd0);
    chk("async rst in_read", {28'd0, in_read0}, 32'd0);
    in_empty = 4'hF;
    @(negedge ck);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fire(4'b1100, 4'hF, 1'b0, 4'b0011, 4'b0000);
      if (i == 3) push0(8'h0C);
    end
    for (int i = 0; i < 3; i++) fire(4'hF, 4'hF, 1'b0, 4'b0000, 4'b0000);

    chk("dut0 pending writes", q0.size(), 32'd0);
    chk("dut1 pending writes", q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csdf_rr_acc.md
CSDF_RR_ACC -- requirements
Module: csdf_rr_acc

Interface
REQ-001 SHALL have parameter PORTS, default 2: input ports per flow.
REQ-002 SHALL have parameter FLUX, default 2: independent flows (channels), 1..16.
REQ-003 SHALL have parameter WIDTH, default 8: token width; the top TW = max(1,clog2(FLUX)) bits are the tag and the low DW = WIDTH-TW bits are data.
REQ-004 SHALL have parameter NUM_OP, default 4: firings accumulated per output token, at least 1.
REQ-005 SHALL have parameter MODE, default 0: 0 = wrapping sum, 1 = saturating sum, 2 = maximum.
REQ-006 SHALL have port ck, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port in_data, input, WIDTH*PORTS*FLUX bits: token for flow f, port p at bits [(f*PORTS+p)*WIDTH +: WIDTH].
REQ-009 SHALL have port in_empty, input, PORTS*FLUX bits: bit f*PORTS+p is the empty flag of flow f, port p.
REQ-010 SHALL have port in_read, output, PORTS*FLUX bits: combinational read strobes, using the same indexing as in_empty.
REQ-011 SHALL have port out0_full, input, 1 bit: downstream full; low guarantees room for one write at the next edge.
REQ-012 SHALL have port out0_wr, output, 1 bit: registered write strobe.
REQ-013 SHALL have port out0_data, output, WIDTH bits: registered {tag, result}.

Function
REQ-014 SHALL consider flow f ready when every in_empty bit of flow f is 0.
REQ-015 SHALL keep a counter cnt[f] (0..NUM_OP-1) and an accumulator acc[f] (DW bits) for each flow.
REQ-016 SHALL consider flow f eligible when it is ready and either cnt[f] < NUM_OP-1 or out0_full = 0.
REQ-017 SHALL grant at most one eligible flow per cycle, round-robin, searching upward from the flow after the last granted flow (rr_ptr) with wrap-around.
REQ-018 SHALL, in the grant cycle, assert in_read for all PORTS bits of the granted flow, keep all other in_read bits 0, and update rr_ptr to the granted flow.
REQ-019 SHALL form the firing value v by combining the DW data bits of each port (tag bits ignored) per MODE, in the same width and mode rules as REQ-020.
REQ-020 SHALL compute n = acc op v, where op is a DW-bit wrapping sum for MODE 0, a sum clamped to 2^DW-1 for MODE 1, and max for MODE 2.
REQ-021 SHALL, when the granted cnt < NUM_OP-1, set acc <= n and cnt <= cnt+1, with no write.
REQ-022 SHALL, when the granted cnt = NUM_OP-1, at the next edge set out0_data <= {f[TW-1:0], n}, out0_wr <= 1, acc[f] <= 0 and cnt[f] <= 0.
REQ-023 SHALL have a latency of one cycle from the completing grant to out0_wr; out0_wr is a single-cycle pulse.
REQ-024 SHALL make out0_wr 0 in every cycle not preceded by a completing grant, with out0_data holding its last value.
REQ-025 SHALL, with NUM_OP = 1, make every firing a completing firing, so firings require out0_full = 0.
REQ-026 SHALL leave a non-granted flow's state unchanged, with partial accumulations preserved across interleaving.
REQ-027 SHALL, when no flow is eligible, drive all in_read 0 and change no state except clearing out0_wr.
REQ-028 SHALL, when a flow is ready but blocked only by out0_full, not block other flows that are eligible.
REQ-029 SHALL not allow an in_read bit to assert while its in_empty bit is 1.

Reset
REQ-030 SHALL, while rst = 1, hold in_read = 0, out0_wr = 0, out0_data = 0, all cnt = 0, all acc = 0 and rr_ptr = FLUX-1, so flow 0 has first priority.
REQ-031 SHALL, on reset asserted mid-accumulation, discard all partial results immediately without waiting for a clock edge.

Verification
REQ-032 SHALL cover: defaults, MODE 0; flow 0 fed {1,2} ×4 with out0_full = 0 -> one out0_wr one cycle after the 4th read, out0_data = {0, 12}.
REQ-033 SHALL cover: both flows always ready -> grants alternate 0,1,0,1; each flow outputs after 4 of its own firings, and tags are correct.
REQ-034 SHALL cover: flow 1 at cnt 3, out0_full = 1, flow 0 ready -> flow 0 keeps firing, flow 1 is not read; out0_full drops -> flow 1 fires and writes on the next cycle.
REQ-035 SHALL cover: MODE 1, DW = 7, inputs {100,100} -> result 127; MODE 0 with the same inputs -> (800 mod 128) = 32.
REQ-036 SHALL cover: rst pulsed asynchronously between edges with flow 0 at cnt 2 -> outputs 0 immediately; a later 4-firing run produces a clean result.
